// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/ack bus between fetch stage and memory
interface fetch_stage_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;

  // fetch stage drives the request side
  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemRData
  );

  // instruction memory answers with ack and data
  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemRData
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one-entry skid buffer and redirect drop
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master imem,
  input  logic          StallD,
  input  logic          PCSrcE,
  input  logic [31:0]   BranchTargetE,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD
);

  // FETCH: request for r_pc outstanding
  // BUFFERED: word parked in skid buffer, memory idle
  // DROP: request for a stale address outstanding, its data is thrown away
  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_DROP     = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_buf_valid;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_drop_addr_nxt;
  logic [31:0] w_buf_instr_nxt;
  logic [31:0] w_buf_pc_nxt;
  logic        w_buf_valid_nxt;
  logic [31:0] w_instr_d_nxt;
  logic [31:0] w_pc_d_nxt;
  logic [31:0] w_pc_plus4_d_nxt;
  logic        w_valid_d_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_buf_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_ack;

  // PC arithmetic wraps naturally at 2^32; redirect targets are forced word-aligned
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_buf_pc_plus4 = r_buf_pc + 32'd4;
  assign w_redirect_pc  = BranchTargetE & 32'hFFFF_FFFC;
  assign w_ack          = imem.IMemAck;

  // Request is live in FETCH and DROP; gated by rst so nothing leaves during reset
  assign imem.IMemReq  = !rst && (r_state != S_BUFFERED);
  assign imem.IMemAddr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;
  assign ValidD   = r_valid_d;

  // State, PC, skid buffer and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drop_addr  <= 32'd0;
      r_buf_instr  <= 32'd0;
      r_buf_pc     <= 32'd0;
      r_buf_valid  <= 1'b0;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop_addr  <= w_drop_addr_nxt;
      r_buf_instr  <= w_buf_instr_nxt;
      r_buf_pc     <= w_buf_pc_nxt;
      r_buf_valid  <= w_buf_valid_nxt;
      r_instr_d    <= w_instr_d_nxt;
      r_pc_d       <= w_pc_d_nxt;
      r_pc_plus4_d <= w_pc_plus4_d_nxt;
      r_valid_d    <= w_valid_d_nxt;
    end
  end

  // Next-state and datapath selection; a redirect overrides everything else
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_addr_nxt  = r_drop_addr;
    w_buf_instr_nxt  = r_buf_instr;
    w_buf_pc_nxt     = r_buf_pc;
    w_buf_valid_nxt  = r_buf_valid;
    w_instr_d_nxt    = r_instr_d;
    w_pc_d_nxt       = r_pc_d;
    w_pc_plus4_d_nxt = r_pc_plus4_d;
    w_valid_d_nxt    = r_valid_d;

    if (PCSrcE) begin
      // Squash decode slot and buffer, restart fetch at the aligned target
      w_pc_nxt        = w_redirect_pc;
      w_valid_d_nxt   = 1'b0;
      w_instr_d_nxt   = NOP_INSTR;
      w_buf_valid_nxt = 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (!w_ack) begin
            // The old request cannot be withdrawn; keep presenting it until it completes
            w_drop_addr_nxt = r_pc;
            w_state_nxt     = S_DROP;
          end
        end
        S_BUFFERED: begin
          w_state_nxt = S_FETCH;
        end
        S_DROP: begin
          if (w_ack) w_state_nxt = S_FETCH;
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            w_pc_nxt = w_pc_plus4;
            if (StallD) begin
              // Decode is busy: park the word and pause the memory
              w_buf_instr_nxt = imem.IMemRData;
              w_buf_pc_nxt    = r_pc;
              w_buf_valid_nxt = 1'b1;
              w_state_nxt     = S_BUFFERED;
            end else begin
              w_instr_d_nxt    = imem.IMemRData;
              w_pc_d_nxt       = r_pc;
              w_pc_plus4_d_nxt = w_pc_plus4;
              w_valid_d_nxt    = 1'b1;
            end
          end else if (!StallD) begin
            // Memory not ready: hand decode a bubble
            w_instr_d_nxt = NOP_INSTR;
            w_valid_d_nxt = 1'b0;
          end
        end
        S_BUFFERED: begin
          if (!StallD) begin
            if (r_buf_valid) begin
              w_instr_d_nxt    = r_buf_instr;
              w_pc_d_nxt       = r_buf_pc;
              w_pc_plus4_d_nxt = w_buf_pc_plus4;
              w_valid_d_nxt    = 1'b1;
            end
            w_buf_valid_nxt = 1'b0;
            w_state_nxt     = S_FETCH;
          end
        end
        S_DROP: begin
          // Data returned here belongs to a squashed path and never reaches IF/ID
          if (w_ack) w_state_nxt = S_FETCH;
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

endmodule
